aes_block_serializer: RTL and testbench
=======================================

Name: aes_block_serializer

Overview:
- Transmit side of the AES engine's 32-bit HWPE stream datapath.
- Accepts one 128-bit result block from the AES core over a valid/ready handshake.
- Emits the block as four 32-bit beats on an outgoing HWPE-style stream with full valid/ready backpressure.
- Reports per-block completion and a running block count to the controller.

Parameters:
- DATA_WIDTH, 32, stream beat width in bits.
- BLOCK_WIDTH, 128, input block width in bits; must be an integer multiple of DATA_WIDTH.
- BEATS, BLOCK_WIDTH/DATA_WIDTH (4), beats per block; derived, not overridden.
- CNT_WIDTH, 16, width of the sent-block counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear from controller.
- blk_valid_i  in  1  result block available.
- blk_ready_o  out  1  serializer accepts the block this cycle.
- blk_data_i  in  BLOCK_WIDTH  result block.
- out_valid_o  out  1  stream beat valid.
- out_ready_i  in  1  stream sink ready.
- out_data_o  out  DATA_WIDTH  stream beat data.
- out_strb_o  out  DATA_WIDTH/8  byte strobes.
- busy_o  out  1  block held and not fully sent.
- block_done_o  out  1  one-cycle pulse: last beat of a block handshaken.
- blocks_sent_o  out  CNT_WIDTH  blocks completed since reset/clear.

Behaviour:
- Reset (rst_i=1 at an edge) sets: state IDLE, beat_cnt 0, block register 0, out_valid_o 0, block_done_o 0, blocks_sent_o 0, busy_o 0, out_data_o 0, out_strb_o 0.
- In IDLE, blk_ready_o=1.
- Reset or clear asserted mid-block drops the held block immediately. No further beats are emitted.
- States:
  - IDLE: no block held.
  - SEND: block held, beats pending.
- IDLE -> SEND when blk_valid_i && blk_ready_o. The block is latched, beat_cnt=0, and out_valid_o=1 from the next cycle (1-cycle latency).
- SEND: out_valid_o=1. out_data_o = block[DATA_WIDTH*beat_cnt +: DATA_WIDTH], so beat 0 is bits [31:0] and beat 3 is bits [127:96]. out_strb_o all ones.
- Beat handshake is out_valid_o && out_ready_i; on a handshake, beat_cnt increments.
- While out_ready_i=0, out_valid_o, out_data_o and out_strb_o are held stable. Valid is never withdrawn without a handshake.
- Last beat (beat_cnt==BEATS-1) handshake:
  - block_done_o=1 for the following cycle.
  - blocks_sent_o increments, wrapping 0xFFFF -> 0x0000.
  - beat_cnt returns to 0.
- blk_ready_o is 1 in IDLE, or in SEND when beat_cnt==BEATS-1 && out_ready_i. This path is combinational from out_ready_i.
  - Last-beat handshake with a block also accepted: the new block is latched and the state stays SEND. The next cycle presents its beat 0, giving back-to-back blocks with no bubble.
  - Last-beat handshake with no block accepted: state -> IDLE, out_valid_o=0 the next cycle, out_data_o/out_strb_o forced to 0 in IDLE.
- blk_ready_o=0 in SEND otherwise; blk_valid_i is ignored.
- busy_o = (state==SEND).
- clear_i=1 acts like rst_i for all state, including blocks_sent_o. blk_ready_o=0 during the clear cycle, so no block is accepted. rst_i has priority over clear_i.
- Clear in the same cycle as a last-beat handshake: clear wins. There is no block_done_o pulse and no count increment, though the sink has seen the beat.
- blk_data_i is sampled only on acceptance; later changes are ignored.

Test Plan:
- Single block, sink always ready: blk_data_i=0x33333333_22222222_11111111_00000000 -> out_data_o 0x00000000, 0x11111111, 0x22222222, 0x33333333 on 4 consecutive cycles starting 1 cycle after acceptance; block_done_o pulses once; blocks_sent_o=1; then IDLE with out_valid_o=0.
- Backpressure: out_ready_i low for 3 cycles during beat 1 -> out_data_o holds 0x11111111 with out_valid_o=1 throughout; total beats=4, no duplicates or drops.
- Back-to-back: second block 0xDDDD..., blk_valid_i high during the first block's last beat -> blk_ready_o=1 in that cycle; beat 0 of block 2 follows beat 3 of block 1 with no idle cycle; blocks_sent_o=2.
- Clear mid-block: clear_i pulsed after beat 1 handshake -> out_valid_o=0 the next cycle, blocks_sent_o=0, block_done_o never pulses; a new block then sends all 4 beats from beat 0.
- Reset mid-block and counter wrap: rst_i after beat 2 -> all outputs at reset values the next cycle. Separately, preset blocks_sent_o to 0xFFFF via 65535 blocks (or a forced state) -> next block gives 0x0000.

Source files
------------

// File: rtl/aes_block_serializer.sv
// -----------------------------------------------------------------------------
// aes_block_serializer
//
// Transmit side of the AES engine's HWPE stream datapath. One BLOCK_WIDTH-bit
// result block is taken from the AES core and sent as BEATS beats of
// DATA_WIDTH bits, least significant word first, on an outgoing stream that
// the sink can stall. Each completed block raises a one-cycle done pulse and
// increments a wrapping sent-block counter.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset
//   clear_i        in   synchronous soft clear (same effect as rst_i)
//   blk_valid_i    in   result block available
//   blk_ready_o    out  block accepted this cycle (combinational)
//   blk_data_i     in   result block, sampled only on acceptance
//   out_valid_o    out  stream beat valid
//   out_ready_i    in   stream sink ready
//   out_data_o     out  stream beat data
//   out_strb_o     out  byte strobes (all ones while a beat is valid)
//   busy_o         out  block held and not fully sent
//   block_done_o   out  one-cycle pulse after the last beat handshake
//   blocks_sent_o  out  blocks completed since reset/clear (wraps)
//   dbg_state_o    out  FSM state (0 = IDLE, 1 = SEND)
//   dbg_beat_cnt_o out  index of the beat currently presented
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. A producer never withdraws valid and never changes its data
// until that transfer has happened. out_valid_o follows this rule; the
// serializer itself may raise or lower blk_ready_o at any time.
//
// BLOCK_WIDTH must be an integer multiple of DATA_WIDTH.
// -----------------------------------------------------------------------------
module aes_block_serializer #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int BLOCK_WIDTH = 128,
  parameter  int CNT_WIDTH   = 16,
  localparam int BEATS       = BLOCK_WIDTH / DATA_WIDTH,
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int STRB_W      = DATA_WIDTH / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [BLOCK_WIDTH-1:0] blk_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic [STRB_W-1:0]      out_strb_o,
  output logic                   busy_o,
  output logic                   block_done_o,
  output logic [CNT_WIDTH-1:0]   blocks_sent_o,
  output logic                   dbg_state_o,
  output logic [BEAT_W-1:0]      dbg_beat_cnt_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                 r_state;
  logic [BEAT_W-1:0]      r_beat_cnt;
  logic [BLOCK_WIDTH-1:0] r_block;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [STRB_W-1:0]      r_out_strb;
  logic                   r_done;
  logic [CNT_WIDTH-1:0]   r_blocks_sent;

  logic                   w_soft_reset;
  logic                   w_last_beat;
  logic                   w_beat_hs;
  logic                   w_blk_ready;
  logic                   w_accept;
  logic [BEAT_W-1:0]      w_beat_inc;
  logic [DATA_WIDTH-1:0]  w_in_word0;
  logic [DATA_WIDTH-1:0]  w_words [BEATS];

  // Held block viewed as an array of beats; beat 0 is the least significant word.
  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      w_words[i] = r_block[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_soft_reset = rst_i || clear_i;
  assign w_last_beat  = (r_beat_cnt == BEAT_W'(BEATS - 1));
  assign w_beat_hs    = r_out_valid && out_ready_i;
  assign w_beat_inc   = r_beat_cnt + BEAT_W'(1);
  assign w_in_word0   = blk_data_i[DATA_WIDTH-1:0];

  // A new block is taken when idle, or in the very cycle the last beat of the
  // current block leaves; the latter is what gives bubble-free back-to-back
  // blocks. Ready is held low during reset/clear so a block offered in that
  // cycle is never silently dropped.
  always_comb begin
    w_blk_ready = 1'b0;
    if (!w_soft_reset) begin
      if (r_state == ST_IDLE) begin
        w_blk_ready = 1'b1;
      end else if (w_last_beat && out_ready_i) begin
        w_blk_ready = 1'b1;
      end
    end
  end

  assign w_accept = blk_valid_i && w_blk_ready;

  always_ff @(posedge clk_i) begin
    if (w_soft_reset) begin
      r_state       <= ST_IDLE;
      r_beat_cnt    <= '0;
      r_block       <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_strb    <= '0;
      r_done        <= 1'b0;
      r_blocks_sent <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_block     <= blk_data_i;
            r_beat_cnt  <= '0;
            r_state     <= ST_SEND;
            r_out_valid <= 1'b1;
            r_out_data  <= w_in_word0;
            r_out_strb  <= '1;
          end
        end

        ST_SEND: begin
          // Without a handshake every output register keeps its value,
          // which keeps the beat stable under backpressure.
          if (w_beat_hs) begin
            if (w_last_beat) begin
              r_done        <= 1'b1;
              r_blocks_sent <= r_blocks_sent + CNT_WIDTH'(1);
              r_beat_cnt    <= '0;
              if (w_accept) begin
                // Next block's beat 0 goes out straight from the input bus.
                r_block    <= blk_data_i;
                r_out_data <= w_in_word0;
              end else begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_out_strb  <= '0;
              end
            end else begin
              r_beat_cnt <= w_beat_inc;
              r_out_data <= w_words[w_beat_inc];
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign blk_ready_o    = w_blk_ready;
  assign out_valid_o    = r_out_valid;
  assign out_data_o     = r_out_data;
  assign out_strb_o     = r_out_strb;
  assign busy_o         = (r_state == ST_SEND);
  assign block_done_o   = r_done;
  assign blocks_sent_o  = r_blocks_sent;
  assign dbg_state_o    = r_state;
  assign dbg_beat_cnt_o = r_beat_cnt;

endmodule

// File: tb/tb_aes_block_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for aes_block_serializer.
// The reference model is a queue of the 32-bit words still owed to the sink:
// accepting a block appends its four words, every sink handshake removes the
// front word, and emptying the queue completes a block.
// -----------------------------------------------------------------------------
module tb_aes_block_serializer;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_i, clear_i, blk_valid_i, out_ready_i;
  logic [127:0] blk_data_i;
  logic         blk_ready_o, out_valid_o, busy_o, block_done_o;
  logic [31:0]  out_data_o;
  logic [3:0]   out_strb_o;
  logic [15:0]  blocks_sent_o;
  logic         dbg_state_o;
  logic [1:0]   dbg_beat_cnt_o;

  always #5 clk = ~clk;

  aes_block_serializer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .blk_valid_i   (blk_valid_i),
    .blk_ready_o   (blk_ready_o),
    .blk_data_i    (blk_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_strb_o    (out_strb_o),
    .busy_o        (busy_o),
    .block_done_o  (block_done_o),
    .blocks_sent_o (blocks_sent_o),
    .dbg_state_o   (dbg_state_o),
    .dbg_beat_cnt_o(dbg_beat_cnt_o)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt = 16'h0;
  logic        exp_done = 1'b0;
  logic        exp_rdy;
  logic        rdy_seen;
  logic        hs_seen;
  logic [31:0] hs_data;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [54:0] exp_vec();
    logic ev;
    ev = (exp_q.size() != 0);
    return {ev, ev, exp_done, (ev ? 4'hF : 4'h0), (ev ? exp_q[0] : 32'h0), exp_cnt};
  endfunction

  function automatic logic [54:0] obs_vec();
    return {out_valid_o, busy_o, block_done_o, out_strb_o, out_data_o, blocks_sent_o};
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge: applies inputs, records what the sink and the
  // producer see before the rising edge, advances the model across that
  // edge and returns at the next falling edge.
  task automatic step(input logic v, input logic [127:0] d, input logic rdy,
                      input logic clr, input logic rs);
    blk_valid_i = v;
    blk_data_i  = d;
    out_ready_i = rdy;
    clear_i     = clr;
    rst_i       = rs;
    #1;
    rdy_seen = blk_ready_o;
    hs_seen  = out_valid_o && rdy;
    hs_data  = out_data_o;
    exp_rdy  = !rs && !clr && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
    if (rs || clr) begin
      exp_q.delete();
      exp_cnt  = 16'h0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (exp_q.size() != 0 && rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          exp_done = 1'b1;
          exp_cnt  = exp_cnt + 16'd1;
        end
      end
      if (v && exp_rdy) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(d[32*i +: 32]);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    vectors++;
    if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
      miscompares++;
      $display("FAIL reset_vec got %h expected %h", {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
    end
    vectors++;
    if ({out_valid_o, busy_o, block_done_o, out_strb_o, out_data_o, blocks_sent_o} !== 55'h0) begin
      miscompares++;
      $display("FAIL reset_zero got %h expected 0", obs_vec());
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (blk_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_ready got %b expected 1", blk_ready_o);
    end
  endtask

  task automatic test_single();
    logic [127:0] blk;
    logic [31:0]  seen[$];
    int           dones;
    blk   = 128'h33333333_22222222_11111111_00000000;
    dones = 0;
    step(1'b1, blk, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({out_valid_o, out_data_o} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL single_latency got v=%b d=%h expected v=1 d=00000000", out_valid_o, out_data_o);
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (hs_seen) seen.push_back(hs_data);
      if (block_done_o) dones++;
      vectors++;
      if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
        miscompares++;
        $display("FAIL single_cyc%0d got %h expected %h", c, {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
      end
    end
    vectors++;
    if (seen.size() != 4) begin
      miscompares++;
      $display("FAIL single_beats got %0d expected 4", seen.size());
    end else if ({seen[3], seen[2], seen[1], seen[0]} !== blk) begin
      miscompares++;
      $display("FAIL single_order got %h expected %h", {seen[3], seen[2], seen[1], seen[0]}, blk);
    end
    vectors++;
    if ({dones[7:0], blocks_sent_o, out_valid_o} !== {8'd1, 16'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_done got dones=%0d cnt=%0d v=%b expected 1 1 0", dones, blocks_sent_o, out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] blk;
    logic [31:0]  seen[$];
    logic         pat[8];
    blk = 128'h33333333_22222222_11111111_00000000;
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    step(1'b1, blk, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, pat[k], 1'b0, 1'b0);
      if (hs_seen) seen.push_back(hs_data);
      vectors++;
      if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
        miscompares++;
        $display("FAIL bp_cyc%0d got %h expected %h", k, {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
      end
      if (k < 4) begin
        vectors++;
        if ({out_valid_o, out_data_o} !== {1'b1, 32'h11111111}) begin
          miscompares++;
          $display("FAIL bp_hold%0d got v=%b d=%h expected v=1 d=11111111", k, out_valid_o, out_data_o);
        end
      end
    end
    vectors++;
    if (seen.size() != 4) begin
      miscompares++;
      $display("FAIL bp_beats got %0d expected 4", seen.size());
    end else if ({seen[3], seen[2], seen[1], seen[0]} !== blk) begin
      miscompares++;
      $display("FAIL bp_order got %h expected %h", {seen[3], seen[2], seen[1], seen[0]}, blk);
    end
    vectors++;
    if (blocks_sent_o !== 16'd2) begin
      miscompares++;
      $display("FAIL bp_count got %0d expected 2", blocks_sent_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] b1, b2;
    logic [31:0]  seen[$];
    int           first_hs, last_hs;
    logic         took2;
    b1 = rand_blk();
    b2 = {4{32'hDDDDDDDD}};
    took2 = 1'b0;
    first_hs = -1;
    last_hs  = -1;
    step(1'b1, b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step(!took2, b2, 1'b1, 1'b0, 1'b0);
      if (hs_seen) begin
        seen.push_back(hs_data);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      if (rdy_seen && !took2) begin
        took2 = 1'b1;
        vectors++;
        if ({hs_seen, hs_data} !== {1'b1, b1[127:96]}) begin
          miscompares++;
          $display("FAIL b2b_ready_when got hs=%b d=%h expected hs=1 d=%h", hs_seen, hs_data, b1[127:96]);
        end
      end
      vectors++;
      if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
        miscompares++;
        $display("FAIL b2b_cyc%0d got %h expected %h", c, {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
      end
    end
    vectors++;
    if (seen.size() != 8 || (last_hs - first_hs) != 7) begin
      miscompares++;
      $display("FAIL b2b_bubble got beats=%0d span=%0d expected beats=8 span=7", seen.size(), last_hs - first_hs);
    end else if ({seen[7], seen[6], seen[5], seen[4], seen[3], seen[2], seen[1], seen[0]} !== {b2, b1}) begin
      miscompares++;
      $display("FAIL b2b_order got %h%h expected %h%h", {seen[7], seen[6], seen[5], seen[4]},
               {seen[3], seen[2], seen[1], seen[0]}, b2, b1);
    end
    vectors++;
    if (blocks_sent_o !== 16'd4) begin
      miscompares++;
      $display("FAIL b2b_count got %0d expected 4", blocks_sent_o);
    end
  endtask

  task automatic test_clear_mid();
    logic [127:0] blk;
    logic [31:0]  seen[$];
    int           dones;
    blk   = rand_blk();
    dones = 0;
    step(1'b1, rand_blk(), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // clear after beat 1, with a block offered in the same cycle
    step(1'b1, rand_blk(), 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({rdy_seen, out_valid_o, busy_o, block_done_o, blocks_sent_o} !== 20'h0) begin
      miscompares++;
      $display("FAIL clear_state got rdy=%b v=%b busy=%b done=%b cnt=%0d expected all 0",
               rdy_seen, out_valid_o, busy_o, block_done_o, blocks_sent_o);
    end
    step(1'b1, blk, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (hs_seen) seen.push_back(hs_data);
      if (block_done_o) dones++;
      vectors++;
      if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
        miscompares++;
        $display("FAIL clear_cyc%0d got %h expected %h", c, {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
      end
    end
    vectors++;
    if (seen.size() != 4 || dones != 1 || blocks_sent_o !== 16'd1) begin
      miscompares++;
      $display("FAIL clear_resend got beats=%0d dones=%0d cnt=%0d expected 4 1 1", seen.size(), dones, blocks_sent_o);
    end else if ({seen[3], seen[2], seen[1], seen[0]} !== blk) begin
      miscompares++;
      $display("FAIL clear_order got %h expected %h", {seen[3], seen[2], seen[1], seen[0]}, blk);
    end
    // clear coinciding with the last-beat handshake: clear wins
    step(1'b1, rand_blk(), 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if ({out_valid_o, block_done_o, blocks_sent_o} !== 18'h0) begin
      miscompares++;
      $display("FAIL clear_last got v=%b done=%b cnt=%0d expected 0 0 0", out_valid_o, block_done_o, blocks_sent_o);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, rand_blk(), 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (obs_vec() !== 55'h0) begin
      miscompares++;
      $display("FAIL reset_mid got %h expected 0", obs_vec());
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
      miscompares++;
      $display("FAIL reset_mid_after got %h expected %h", {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
    end
  endtask

  task automatic test_wrap();
    force dut.r_blocks_sent = 16'hFFFF;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    release dut.r_blocks_sent;
    exp_cnt = 16'hFFFF;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (blocks_sent_o !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preset got %h expected ffff", blocks_sent_o);
    end
    step(1'b1, rand_blk(), 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
        miscompares++;
        $display("FAIL wrap_cyc%0d got %h expected %h", c, {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
      end
    end
    vectors++;
    if (blocks_sent_o !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_value got %h expected 0000", blocks_sent_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), rand_blk(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 59) == 0), 1'b0);
      vectors++;
      if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
        miscompares++;
        $display("FAIL random_cyc%0d got %h expected %h", c, {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
      end
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({rdy_seen, obs_vec()} !== {exp_rdy, exp_vec()}) begin
        miscompares++;
        $display("FAIL drain_cyc%0d got %h expected %h", c, {rdy_seen, obs_vec()}, {exp_rdy, exp_vec()});
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_i       = 1'b1;
    clear_i     = 1'b0;
    blk_valid_i = 1'b0;
    blk_data_i  = '0;
    out_ready_i = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_clear_mid();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
